// File: rtl/ascon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_arbiter
//  Description : Round-robin arbiter and sequencer sharing one Ascon AEAD core
//                among N requesters. Latches the winning job's operands,
//                drives the core start/release handshake, captures the core
//                result, checks the tag on decryption and aborts a hung core
//                through a watchdog.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    req_valid_i   [N]   job offered by requester i
//    req_ready_o   [N]   one-cycle accept pulse to the granted requester
//    req_*_i             per-requester operands, requester i at [i*W +: W]
//    rsp_valid_o   [N]   response for requester i, held until rsp_ready_i[i]
//    rsp_ready_i   [N]   response accept
//    rsp_data_o/tag_o    shared result payload and computed tag
//    rsp_auth_ok_o       1 = encrypt, or decrypt with matching tag
//    rsp_timeout_o       1 = job aborted by the watchdog
//    busy_o              high whenever a job is in flight
//    core_*_o            registered operands and start/reset to the core
//    core_out_i/tag_i    core results, core_ready_i core done level
// ============================================================================
module ascon_arbiter #(
    parameter int N       = 2,
    parameter int K       = 128,
    parameter int L       = 40,
    parameter int Y       = 104,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    input  logic [N*K-1:0]   req_key_i,
    input  logic [N*128-1:0] req_nonce_i,
    input  logic [N*L-1:0]   req_ad_i,
    input  logic [N*Y-1:0]   req_data_i,
    input  logic [N-1:0]     req_decrypt_i,
    input  logic [N*128-1:0] req_tag_i,
    output logic [N-1:0]     rsp_valid_o,
    input  logic [N-1:0]     rsp_ready_i,
    output logic [Y-1:0]     rsp_data_o,
    output logic [127:0]     rsp_tag_o,
    output logic             rsp_auth_ok_o,
    output logic             rsp_timeout_o,
    output logic             busy_o,
    output logic [K-1:0]     core_key_o,
    output logic [127:0]     core_nonce_o,
    output logic [L-1:0]     core_ad_o,
    output logic [Y-1:0]     core_data_o,
    output logic             core_decrypt_o,
    output logic             core_start_o,
    output logic             core_rst_o,
    input  logic [Y-1:0]     core_out_i,
    input  logic [127:0]     core_tag_i,
    input  logic             core_ready_i
);

    localparam int         c_IW      = $clog2(N);
    localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ARB     = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_TOUT    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            state_q;
    logic [c_IW-1:0]   ptr_q;
    logic [c_IW-1:0]   gnt_q;
    logic [7:0]        wdog_q;
    logic [127:0]      exp_tag_q;
    logic [N-1:0]      rsp_valid_q;
    logic [Y-1:0]      rsp_data_q;
    logic [127:0]      rsp_tag_q;
    logic              rsp_auth_ok_q;
    logic              rsp_timeout_q;
    logic              busy_q;
    logic [K-1:0]      core_key_q;
    logic [127:0]      core_nonce_q;
    logic [L-1:0]      core_ad_q;
    logic [Y-1:0]      core_data_q;
    logic              core_decrypt_q;
    logic              core_start_q;
    logic              wd_rst_q;

    logic [c_IW-1:0]   gnt_d;
    logic              any_d;
    logic              tag_match_d;

    // Round-robin search from ptr+1. The offsets are walked from farthest to
    // nearest so the nearest valid requester is assigned last and wins.
    always_comb begin
        logic [c_IW-1:0] idx;
        idx   = '0;
        gnt_d = ptr_q;
        any_d = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = c_IW'((int'(ptr_q) + k) % N);
            if (req_valid_i[idx]) begin
                gnt_d = idx;
                any_d = 1'b1;
            end
        end
    end

    // Accept pulse is combinational so it coincides with the operand latch edge.
    always_comb begin
        req_ready_o = '0;
        if (!rst && state_q == S_ARB && any_d) begin
            req_ready_o[gnt_d] = 1'b1;
        end
    end

    assign tag_match_d = (core_tag_i == exp_tag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_ARB;
            ptr_q          <= c_IW'(N - 1);
            gnt_q          <= '0;
            wdog_q         <= '0;
            exp_tag_q      <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            rsp_tag_q      <= '0;
            rsp_auth_ok_q  <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            core_key_q     <= '0;
            core_nonce_q   <= '0;
            core_ad_q      <= '0;
            core_data_q    <= '0;
            core_decrypt_q <= 1'b0;
            core_start_q   <= 1'b0;
            wd_rst_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            wd_rst_q     <= 1'b0;
            case (state_q)
                S_ARB: begin
                    if (any_d) begin
                        core_key_q     <= req_key_i[int'(gnt_d)*K +: K];
                        core_nonce_q   <= req_nonce_i[int'(gnt_d)*128 +: 128];
                        core_ad_q      <= req_ad_i[int'(gnt_d)*L +: L];
                        core_data_q    <= req_data_i[int'(gnt_d)*Y +: Y];
                        core_decrypt_q <= req_decrypt_i[gnt_d];
                        exp_tag_q      <= req_tag_i[int'(gnt_d)*128 +: 128];
                        gnt_q          <= gnt_d;
                        ptr_q          <= gnt_d;
                        core_start_q   <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // core_ready takes precedence over an expiring watchdog.
                    if (core_ready_i) begin
                        rsp_tag_q     <= core_tag_i;
                        rsp_auth_ok_q <= !core_decrypt_q || tag_match_d;
                        // A failed authentication never releases plaintext.
                        rsp_data_q    <= (core_decrypt_q && !tag_match_d) ? '0 : core_out_i;
                        core_start_q  <= 1'b1;
                        state_q       <= S_RELEASE;
                    end else if (wdog_q == c_WD_LAST) begin
                        wd_rst_q <= 1'b1;
                        state_q  <= S_TOUT;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                S_RELEASE: begin
                    rsp_valid_q[gnt_q] <= 1'b1;
                    state_q            <= S_RESP;
                end
                S_TOUT: begin
                    rsp_timeout_q      <= 1'b1;
                    rsp_auth_ok_q      <= 1'b0;
                    rsp_data_q         <= '0;
                    rsp_tag_q          <= '0;
                    rsp_valid_q[gnt_q] <= 1'b1;
                    state_q            <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i[gnt_q]) begin
                        rsp_valid_q   <= '0;
                        rsp_timeout_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_ARB;
                    end
                end
                default: begin
                    state_q <= S_ARB;
                end
            endcase
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_tag_o      = rsp_tag_q;
    assign rsp_auth_ok_o  = rsp_auth_ok_q;
    assign rsp_timeout_o  = rsp_timeout_q;
    assign busy_o         = busy_q;
    assign core_key_o     = core_key_q;
    assign core_nonce_o   = core_nonce_q;
    assign core_ad_o      = core_ad_q;
    assign core_data_o    = core_data_q;
    assign core_decrypt_o = core_decrypt_q;
    assign core_start_o   = core_start_q;
    // The core is held in reset with the arbiter and kicked for one cycle on a watchdog abort.
    assign core_rst_o     = rst | wd_rst_q;

endmodule
`default_nettype wire
